// File: rtl/uart_receiver.sv
// UART receive path: one sample per tx_clk (no oversampling), 1 start bit, DATA_WIDTH
// data bits LSB first, 1 stop bit. Good bytes land in a valid/ready output register.
module uart_receiver #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  tx_clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_rx_s;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ferr;
  logic                  r_ovr;
  logic                  r_busy;
  logic [DATA_WIDTH:0]   w_shift_cat;
  logic                  w_last_bit;
  logic                  w_stop_good;
  logic                  w_stop_bad;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_rx_s = rx_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      logic [SYNC_STAGES:0]   w_chain;
      // Concatenate-then-slice keeps the shift legal for a single stage too.
      assign w_chain = {r_sync, rx_in};
      always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= w_chain[SYNC_STAGES-1:0];
      end
      assign w_rx_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_shift_cat = {w_rx_s, r_shift};
  assign w_last_bit  = (r_cnt == 4'(DATA_WIDTH - 1));
  assign w_stop_good = (r_state == S_STOP) &&  w_rx_s;
  assign w_stop_bad  = (r_state == S_STOP) && !w_rx_s;

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (!w_rx_s)    w_state_nxt = S_DATA;
      S_DATA:      if (w_last_bit) w_state_nxt = S_STOP;
      S_STOP:      w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (w_rx_s)     w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ferr <= w_stop_bad;
      r_ovr  <= 1'b0;
      r_busy <= (w_state_nxt != S_IDLE);
      if ((r_state == S_IDLE) && !w_rx_s) r_cnt <= '0;
      if (r_state == S_DATA) begin
        r_shift <= w_shift_cat[DATA_WIDTH:1];
        r_cnt   <= r_cnt + 4'd1;
      end
      // A consume on the same edge as a new byte frees the slot, so no overrun.
      if (w_stop_good) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: builds a whole line/ready/reset timeline up front, predicts
// every output per edge by scanning the line for frames, then compares each cycle.
module tb_uart_receiver;
  localparam int D = 8;
  localparam int S = 2;
  localparam int T = 3000;

  logic         tx_clk;
  logic         rst_n;
  logic         rx_in;
  logic [D-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  uart_receiver #(.DATA_WIDTH(D), .SYNC_STAGES(S)) dut (
    .tx_clk   (tx_clk),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  // line[k]/rdy[k]: driven just after edge k; rstv[n]: reset held at edge n.
  bit         line   [T];
  bit         rdy    [T];
  bit         rstv   [T+1];
  bit         s      [T];
  int         ev_kind[T];
  logic [7:0] ev_byte[T];
  logic [7:0] e_data [T];
  bit         e_valid[T];
  bit         e_ferr [T];
  bit         e_ovr  [T];
  bit         e_busy [T];

  int checks   = 0;
  int failures = 0;
  int wp;
  int tA5, t00, tFF, t3C, tC3, traise, tE, t5A, tB, t4E, tR, t81;

  task automatic chk(input string name, input int k, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, k, got, exp);
    end
  endtask

  task automatic put_frame(input logic [7:0] b, input bit stop);
    line[wp] = 1'b0;
    for (int i = 0; i < D; i++) line[wp+1+i] = b[i];
    line[wp+D+1] = stop;
    wp += D + 2;
  endtask

  task automatic build();
    int r, hold, gap, rstart;
    for (int k = 0; k < T; k++) begin line[k] = 1'b1; rdy[k] = 1'b1; end
    for (int k = 0; k <= T; k++) rstv[k] = (k <= 4);
    wp = 8;
    tA5 = wp; put_frame(8'hA5, 1'b1); wp += 3;
    t00 = wp; put_frame(8'h00, 1'b1); wp += 1;
    tFF = wp; put_frame(8'hFF, 1'b1); wp += 4;
    t3C = wp; put_frame(8'h3C, 1'b1); wp += 2;
    tC3 = wp; put_frame(8'hC3, 1'b1); wp += 4;
    for (int k = t3C; k < wp; k++) rdy[k] = 1'b0;
    traise = wp; wp += 4;
    tE = wp; put_frame(8'h66, 1'b0);
    for (int i = 0; i < 20; i++) line[wp+i] = 1'b0;
    wp += 23;
    t5A = wp; put_frame(8'h5A, 1'b1); wp += 4;
    tB = wp; put_frame(8'hB1, 1'b1); wp += 2;
    t4E = wp; put_frame(8'h4E, 1'b1); wp += 6;
    for (int k = tB; k <= t4E + 13; k++) rdy[k] = 1'b0;
    rdy[t4E+11] = 1'b1;
    tR = wp; put_frame(8'h00, 1'b1);
    for (int k = tR + 8; k <= tR + 11; k++) rstv[k] = 1'b1;
    wp += 5;
    t81 = wp; put_frame(8'h81, 1'b1); wp += 4;
    rstart = wp;
    while (wp < T - 45) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        line[wp] = 1'b0;
        wp += 1 + $urandom_range(0, 3);
      end else begin
        if (r == 1) begin
          put_frame(8'($urandom_range(0, 255)), 1'b0);
          hold = $urandom_range(0, 6);
          for (int i = 0; i < hold; i++) line[wp+i] = 1'b0;
          wp += hold;
        end else begin
          put_frame(8'($urandom_range(0, 255)), 1'b1);
        end
        gap = $urandom_range(0, 4);
        wp += gap;
      end
    end
    for (int k = rstart; k < T; k++) rdy[k] = ($urandom_range(0, 9) < 7);
  endtask

  // Frame scan over the sampled line, then the valid/ready register per edge.
  task automatic run_model();
    int rel, n, a, p, m;
    logic [7:0] b;
    bit v, rd;
    logic [7:0] dat;
    rel = 0;
    for (int k = 0; k < T; k++) begin
      ev_kind[k] = 0; ev_byte[k] = '0; e_busy[k] = 1'b0;
      if (rstv[k]) begin s[k] = 1'b1; rel = k + 1; end
      else if (k >= rel + S && k - 1 - S >= 0) s[k] = line[k-1-S];
      else s[k] = 1'b1;
    end
    n = 0;
    while (n < T) begin
      if (rstv[n] || s[n]) begin n++; continue; end
      a = -1;
      for (int j = 0; j <= D + 1; j++)
        if (a < 0 && (n + j >= T || rstv[n+j])) a = n + j;
      if (a >= 0) begin
        for (int j = n; j < a && j < T; j++) e_busy[j] = 1'b1;
        n = a;
        continue;
      end
      for (int j = n; j <= n + D; j++) e_busy[j] = 1'b1;
      b = '0;
      for (int i = 0; i < D; i++) b[i] = s[n+1+i];
      p = n + D + 1;
      if (s[p]) begin
        ev_kind[p] = 1; ev_byte[p] = b; n = p + 1;
      end else begin
        ev_kind[p] = 2; e_busy[p] = 1'b1; m = p + 1;
        while (m < T && !rstv[m] && !s[m]) begin e_busy[m] = 1'b1; m++; end
        n = (m < T && !rstv[m]) ? m + 1 : m;
      end
    end
    v = 1'b0; dat = '0;
    for (int k = 0; k < T; k++) begin
      e_ferr[k] = 1'b0; e_ovr[k] = 1'b0;
      if (rstv[k]) begin
        v = 1'b0; dat = '0;
      end else begin
        rd = (k >= 1) ? rdy[k-1] : 1'b0;
        e_ferr[k] = (ev_kind[k] == 2);
        if (ev_kind[k] == 1) begin
          if (!v || rd) begin dat = ev_byte[k]; v = 1'b1; end
          else e_ovr[k] = 1'b1;
        end else if (v && rd) begin
          v = 1'b0;
        end
      end
      e_valid[k] = v; e_data[k] = dat;
    end
  endtask

  task automatic pin_model();
    chk("pin_a5_before", tA5+11, 8'(e_valid[tA5+11]), 8'd0);
    chk("pin_a5_valid",  tA5+12, 8'(e_valid[tA5+12]), 8'd1);
    chk("pin_a5_data",   tA5+12, e_data[tA5+12], 8'hA5);
    chk("pin_a5_consumed", tA5+13, 8'(e_valid[tA5+13]), 8'd0);
    chk("pin_00_data",   t00+12, e_data[t00+12], 8'h00);
    chk("pin_ff_data",   tFF+12, e_data[tFF+12], 8'hFF);
    chk("pin_ff_valid",  tFF+12, 8'(e_valid[tFF+12]), 8'd1);
    chk("pin_ovr_pulse", tC3+12, 8'(e_ovr[tC3+12]), 8'd1);
    chk("pin_ovr_keep",  tC3+12, e_data[tC3+12], 8'h3C);
    chk("pin_held",      traise, 8'(e_valid[traise]), 8'd1);
    chk("pin_drained",   traise+1, 8'(e_valid[traise+1]), 8'd0);
    chk("pin_ferr",      tE+12, 8'(e_ferr[tE+12]), 8'd1);
    chk("pin_ferr_once", tE+13, 8'(e_ferr[tE+13]), 8'd0);
    chk("pin_break_busy", tE+25, 8'(e_busy[tE+25]), 8'd1);
    chk("pin_5a_data",   t5A+12, e_data[t5A+12], 8'h5A);
    chk("pin_swap_data", t4E+12, e_data[t4E+12], 8'h4E);
    chk("pin_swap_old",  t4E+11, e_data[t4E+11], 8'hB1);
    chk("pin_swap_valid", t4E+12, 8'(e_valid[t4E+12]), 8'd1);
    chk("pin_swap_novr", t4E+12, 8'(e_ovr[t4E+12]), 8'd0);
    chk("pin_rst_busy",  tR+9, 8'(e_busy[tR+9]), 8'd0);
    chk("pin_rst_novalid", tR+12, 8'(e_valid[tR+12]), 8'd0);
    chk("pin_81_data",   t81+12, e_data[t81+12], 8'h81);
    chk("pin_81_valid",  t81+12, 8'(e_valid[t81+12]), 8'd1);
  endtask

  initial begin : driver
    rst_n = 1'b0; rx_in = 1'b1; rx_ready = 1'b1;
    build();
    run_model();
    pin_model();
    for (int k = 0; k < T; k++) begin
      @(posedge tx_clk);
      #1;
      rx_in = line[k];
      rx_ready = rdy[k];
      #6;
      rst_n = (k + 1 < T) ? !rstv[k+1] : 1'b1;
    end
  end

  initial begin : compare
    for (int k = 0; k < T; k++) begin
      @(posedge tx_clk);
      #4;
      chk("rx_valid",  k, 8'(rx_valid),  8'(e_valid[k]));
      chk("rx_data",   k, rx_data,       e_data[k]);
      chk("frame_err", k, 8'(frame_err), 8'(e_ferr[k]));
      chk("overrun",   k, 8'(overrun),   8'(e_ovr[k]));
      chk("busy",      k, 8'(busy),      8'(e_busy[k]));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive path, the receive-side counterpart of the team's UART transmitter. It samples one bit per `tx_clk` cycle (bit-rate clock, no oversampling) and deframes 1 start bit (low), `DATA_WIDTH` data bits sent LSB first, and 1 stop bit (high), with no parity. Each good byte is presented on a valid/ready output register. Framing errors and overruns are flagged. It sits on the link input and can be looped back directly to the transmitter's `tx_out`.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, legal range 1–15.
- `SYNC_STAGES`, default 2: synchronizer flops on `rx_in`, legal range 0–3. A value of 0 means `rx_in` is used directly.
- `tx_clk` in 1: bit-rate clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_in` in 1: serial line; idles high.
- `rx_data` out `DATA_WIDTH`: received byte, held while `rx_valid`=1.
- `rx_valid` out 1: `rx_data` holds an unconsumed good byte.
- `rx_ready` in 1: consumer accepts `rx_data` on any edge where `rx_valid`&&`rx_ready`.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the output register is full.
- `busy` out 1: FSM state is not IDLE.

## Operation
- Synchronizer: `rx_s` is `rx_in` delayed by `SYNC_STAGES` flops. These flops reset to 1.
- The FSM has 4 states: IDLE, DATA, STOP, WAIT_HIGH.
  - IDLE: if `rx_s`=0, the start bit is detected. Clear the bit counter and go to DATA. Otherwise stay in IDLE.
  - DATA: each cycle, shift `rx_s` into the MSB of the shift register (shift right), then increment the counter. After `DATA_WIDTH` samples, go to STOP. The first received bit ends in bit 0.
  - STOP: sample `rx_s`.
    - If 1: the frame is good; go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line (break) from being decoded as repeated frames.
- IDLE lasts at least 1 cycle between frames. The transmitter's FINISH plus IDLE gap satisfies this.
- There is no start-bit revalidation; a one-cycle low glitch in IDLE starts a frame.
- Output register on a good stop bit:
  - `rx_valid`=0: load `rx_data`, set `rx_valid`=1.
  - `rx_valid`=1 and `rx_ready`=1 on the same edge: the old byte is consumed and the new byte loaded; `rx_valid` stays 1; no overrun.
  - `rx_valid`=1 and `rx_ready`=0: keep the old byte, drop the new byte, pulse `overrun`.
- Otherwise, `rx_valid`&&`rx_ready` clears `rx_valid`. `rx_data` keeps its last value.
- A frame error never touches `rx_data` or `rx_valid`.
- The bit counter is 4 bits wide and never wraps inside a frame.

## Timing
- Reset values:
  - state IDLE, counter 0, shift register 0
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0
  - synchronizer flops all 1
- Reset mid-frame aborts immediately with no output pulse. After release, the receiver hunts for a new start bit in IDLE. If the line is low at release, that low is treated as a start bit.
- Let edge E be the `tx_clk` edge that drives the start bit onto `rx_in`.
  - The FSM leaves IDLE at edge E+`SYNC_STAGES`+1.
  - Data bit i is sampled at E+`SYNC_STAGES`+2+i.
  - The stop bit is sampled at E+`SYNC_STAGES`+`DATA_WIDTH`+2.
  - `rx_valid`, `frame_err` or `overrun` is visible after that edge. This is edge E+12 with default parameters.
- `frame_err` and `overrun` are high for exactly one cycle per event.
- `busy` is high from the leave-IDLE edge until the return to IDLE, including WAIT_HIGH.
- All outputs are registered. There is no combinational path from `rx_in` or `rx_ready` to any output.

## Test plan
- Loopback from the transmitter, `rx_ready`=1, send 0xA5:
  - `rx_valid` rises 12 edges after start launch with `rx_data`=0xA5.
  - Consumed next edge.
  - `frame_err`=`overrun`=0 throughout.
- Back-to-back 0x00 then 0xFF (minimum IDLE gap), `rx_ready`=1: two `rx_valid` events, 0x00 then 0xFF, no errors.
- `rx_ready`=0, send 0x3C then 0xC3:
  - First byte held as 0x3C.
  - `overrun` pulses once at the second stop sample.
  - Raising `rx_ready` returns 0x3C; then `rx_valid`=0.
- Drive a frame with the stop bit low, then hold `rx_in`=0 for 20 cycles, then high, then send 0x5A:
  - `frame_err` pulses once.
  - `busy` stays high through the low hold.
  - No further frames during the low hold.
  - Then 0x5A is received correctly.
- Hold `rx_valid`=1 with `rx_ready` asserted exactly on the stop-sample edge of the next frame: the new byte is loaded, `rx_valid` stays 1, no `overrun`.
- Assert `rst_n`=0 during data bit 4, release with the line high, then send 0x81:
  - All outputs are at their reset values during reset.
  - No spurious byte.
  - 0x81 is received correctly.
